// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_pkg;

  // Fetch sequencer states: IDLE after reset, REQ with a live request,
  // HOLD with a returned instruction parked behind a stall, DROP with a
  // wrong-path request still waiting for its ack.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction buffer that parks a fetched word while IF/ID is stalled.
// Latency: one cycle from load to visible contents.
// Backpressure: none; the owner decides when to load and clear.
module if_hold_buf #(
  parameter int W = 32
) (
  input  logic         clk_IF,
  input  logic         rst_IF,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] fetched,
  output logic [W-1:0] held
);

  // Clear wins over load so a flushed entry can never survive the same edge.
  always_ff @(posedge clk_IF or posedge rst_IF) begin
    if (rst_IF) begin
      held <= '0;
    end else if (clr) begin
      held <= '0;
    end else if (load) begin
      held <= fetched;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, runs a single-outstanding imem request/ack port, feeds IF/ID.
// Latency: zero extra cycles; the instruction enters IF/ID on the edge where ack is high.
// Backpressure: a stall parks the returned word in a one-entry buffer and drops req until release.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk_IF,
  input  logic        rst_IF,
  input  logic        stall_IF,
  input  logic        redirect_IF,
  input  logic [31:0] target_IF,
  output logic        imem_req_IF,
  output logic [31:0] imem_addr_IF,
  input  logic        imem_ack_IF,
  input  logic [31:0] imem_data_IF,
  output logic [31:0] PC_out_IF,
  output logic [31:0] inst_out_IF,
  output logic        en_out_IF,
  output logic        NOP_out_IF
);

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic        buf_load, buf_clr;
  logic [31:0] buf_inst;
  logic        ready;

  if_hold_buf #(.W(32)) u_hold_buf (
    .clk_IF  (clk_IF),
    .rst_IF  (rst_IF),
    .load    (buf_load),
    .clr     (buf_clr),
    .fetched (imem_data_IF),
    .held    (buf_inst)
  );

  // State, pc and the wrong-path address that DROP keeps on the bus.
  always_ff @(posedge clk_IF or posedge rst_IF) begin
    if (rst_IF) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
    end
  end

  // Memory port and IF/ID outputs; redirect beats stall beats delivery.
  always_comb begin
    ready        = ((state == REQ) && imem_ack_IF) || (state == HOLD);
    imem_req_IF  = (state == REQ) || (state == DROP);
    imem_addr_IF = (state == DROP) ? drop_addr : pc;
    PC_out_IF    = pc;
    inst_out_IF  = '0;
    if (state == HOLD) begin
      inst_out_IF = buf_inst;
    end else if (state == REQ) begin
      inst_out_IF = imem_data_IF;
    end
    en_out_IF  = 1'b1;
    NOP_out_IF = 1'b1;
    if (rst_IF) begin
      en_out_IF  = 1'b0;
      NOP_out_IF = 1'b1;
    end else if (redirect_IF) begin
      en_out_IF  = 1'b1;
      NOP_out_IF = 1'b1;
    end else if (stall_IF) begin
      en_out_IF  = 1'b0;
      NOP_out_IF = 1'b0;
    end else if (ready) begin
      en_out_IF  = 1'b1;
      NOP_out_IF = 1'b0;
    end
  end

  // Next-state and pc update; a redirect with no ack yet must wait out the old request in DROP.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    buf_load      = 1'b0;
    buf_clr       = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_IF) begin
          pc_nxt = target_IF;
        end
      end
      REQ: begin
        if (redirect_IF) begin
          pc_nxt = target_IF;
          if (!imem_ack_IF) begin
            drop_addr_nxt = pc;
            state_nxt     = DROP;
          end
        end else if (imem_ack_IF) begin
          if (stall_IF) begin
            buf_load  = 1'b1;
            state_nxt = HOLD;
          end else begin
            pc_nxt = pc + PC_STEP;
          end
        end
      end
      HOLD: begin
        if (redirect_IF) begin
          pc_nxt    = target_IF;
          buf_clr   = 1'b1;
          state_nxt = REQ;
        end else if (!stall_IF) begin
          pc_nxt    = pc + PC_STEP;
          state_nxt = REQ;
        end
      end
      DROP: begin
        // A fresh redirect only retargets pc; the old request still owns the bus.
        if (redirect_IF) begin
          pc_nxt = target_IF;
        end
        if (imem_ack_IF) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: sequential-program reference stream plus a latency-configurable memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_fetch_unit;

  logic        clk, rst, stall, redirect, ack, req, en, nop;
  logic [31:0] target, mdata, addr, pc_o, inst_o;

  int n_vec = 0;
  int n_err = 0;
  int deliveries = 0;
  int gap = 0;
  int max_gap = 0;
  int lat_mode = 0;          // fixed ack latency, or -1 for random 0..3 per request

  logic [31:0] exp_q[$];     // expected program-order PCs still to be delivered
  logic [31:0] nxt;

  if_fetch_unit dut (
    .clk_IF       (clk),
    .rst_IF       (rst),
    .stall_IF     (stall),
    .redirect_IF  (redirect),
    .target_IF    (target),
    .imem_req_IF  (req),
    .imem_addr_IF (addr),
    .imem_ack_IF  (ack),
    .imem_data_IF (mdata),
    .PC_out_IF    (pc_o),
    .inst_out_IF  (inst_o),
    .en_out_IF    (en),
    .NOP_out_IF   (nop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Content of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req_v);
    n_vec++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back(nxt);
      nxt = nxt + 32'd4;
    end
  endtask

  task automatic q_restart(input logic [31:0] a);
    exp_q.delete();
    nxt = a;
    top_up();
  endtask

  // One cycle of stimulus; a redirect restarts the expected program stream at the target.
  task automatic step(input logic st, input logic rd, input logic [31:0] tg);
    @(negedge clk);
    stall    = st;
    redirect = rd;
    target   = tg;
    if (rd) q_restart(tg);
    top_up();
    #3;
  endtask

  // Memory: acks each request after its latency, checks address stability while pending.
  initial begin : memory
    int wcnt, cur_lat;
    logic pend;
    logic [31:0] pend_addr;
    ack = 1'b0; mdata = '0; wcnt = 0; cur_lat = 0; pend = 1'b0; pend_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !req) begin
        ack = 1'b0; mdata = $urandom; wcnt = 0; pend = 1'b0;
      end else begin
        if (pend) chk32("addr_stable", addr, pend_addr);
        else begin
          cur_lat   = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
          pend_addr = addr;
          pend      = 1'b1;
          wcnt      = 0;
        end
        if (wcnt == cur_lat) begin
          ack = 1'b1; mdata = inst_of(addr); pend = 1'b0;
        end else begin
          ack = 1'b0; mdata = $urandom; wcnt++;
        end
      end
    end
  end

  // Monitor: checks output priority every cycle and pops the scoreboard on each delivery.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk1("rst_en", en, 1'b0);
        chk1("rst_nop", nop, 1'b1);
        chk1("rst_req", req, 1'b0);
        chk32("rst_addr", addr, 32'h0);
        chk32("rst_pc", pc_o, 32'h0);
        chk32("rst_inst", inst_o, 32'h0);
        gap = 0;
      end else if (redirect) begin
        chk1("redir_en", en, 1'b1);
        chk1("redir_nop", nop, 1'b1);
        gap = 0;
      end else if (stall) begin
        chk1("stall_en", en, 1'b0);
        chk1("stall_nop", nop, 1'b0);
      end else begin
        chk1("run_en", en, 1'b1);
        if (!nop) begin
          gap = 0;
          deliveries++;
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_delivery: got pc %h, want none (t=%0t)", pc_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk32("deliv_pc", pc_o, e);
            chk32("deliv_inst", inst_o, inst_of(e));
          end
        end else begin
          gap++;
          if (gap > max_gap) max_gap = gap;
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = '0;
    q_restart(32'h0);
    repeat (3) @(negedge clk);

    // Reset release with zero-wait memory: one IDLE bubble, then 0x0, 0x4, 0x8.
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk1("idle_req", req, 1'b0);
    chk1("idle_nop", nop, 1'b1);
    step(1'b0, 1'b0, '0); chk1("first_req", req, 1'b1); chk32("first_addr", addr, 32'h0);
    step(1'b0, 1'b0, '0); chk32("second_addr", addr, 32'h4);
    step(1'b0, 1'b0, '0); chk32("third_addr", addr, 32'h8);

    // Three-cycle memory: three bubbles with a stable address, then delivery.
    step(1'b0, 1'b1, 32'h200);
    lat_mode = 3;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      chk32("lat3_addr", addr, 32'h200);
      chk1("lat3_nop", nop, 1'b1);
    end
    step(1'b0, 1'b0, '0);
    chk1("lat3_deliv_nop", nop, 1'b0);
    chk32("lat3_deliv_pc", pc_o, 32'h200);

    // Stall in the ack cycle for two cycles, then buffered delivery and next request.
    lat_mode = 0;
    step(1'b0, 1'b1, 32'h300);
    step(1'b1, 1'b0, '0); chk1("stall_ack_en", en, 1'b0);
    step(1'b1, 1'b0, '0); chk1("hold_req", req, 1'b0);
    step(1'b0, 1'b0, '0);
    chk1("hold_rel_nop", nop, 1'b0);
    chk32("hold_rel_pc", pc_o, 32'h300);
    chk32("hold_rel_inst", inst_o, inst_of(32'h300));
    chk1("hold_rel_req", req, 1'b0);
    step(1'b0, 1'b0, '0); chk32("after_hold_addr", addr, 32'h304);

    // Redirect while a two-cycle request is outstanding: old address kept until its ack.
    lat_mode = 2;
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, '0); chk32("drop_addr1", addr, 32'h308); chk1("drop_nop1", nop, 1'b1);
    step(1'b0, 1'b0, '0); chk32("drop_addr2", addr, 32'h308); chk1("drop_nop2", nop, 1'b1);
    step(1'b0, 1'b0, '0); chk32("refetch_addr", addr, 32'h100);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0); chk32("refetch_pc", pc_o, 32'h100); chk1("refetch_nop", nop, 1'b0);

    // Redirect and stall together: redirect wins.
    step(1'b1, 1'b1, 32'h700);
    chk1("redir_stall_en", en, 1'b1);
    chk1("redir_stall_nop", nop, 1'b1);
    lat_mode = 0;
    repeat (6) step(1'b0, 1'b0, '0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0); chk32("wrap_addr0", addr, 32'hFFFF_FFFC); chk32("wrap_pc0", pc_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0); chk32("wrap_addr1", addr, 32'h0); chk32("wrap_pc1", pc_o, 32'h0);

    // Reset while a slow request is outstanding.
    lat_mode = 3;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    q_restart(32'h0);
    #3;
    chk1("midrst_req", req, 1'b0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk1("rerst_idle_req", req, 1'b0);
    step(1'b0, 1'b0, '0); chk1("rerst_req", req, 1'b1); chk32("rerst_addr", addr, 32'h0);

    // Random traffic: random latency, stalls and redirects.
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom);
    end
    lat_mode = 0;
    repeat (10) step(1'b0, 1'b0, '0);

    chk1("progress", deliveries > 300, 1'b1);
    chk1("max_bubble_gap", max_gap <= 12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage pipeline: owns the fetch PC, drives a single-outstanding request/ack port to instruction memory, and produces the PC, instruction, enable and NOP inputs of the IF/ID pipeline register. It absorbs variable memory latency, downstream stalls and EX-stage redirects. Wrong-path or not-yet-returned fetches reach IF/ID as bubbles.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- PC_STEP, 4, sequential PC increment
- clk_IF in 1 — clock; all state updates on the rising edge
- rst_IF in 1 — asynchronous, active-high reset
- stall_IF in 1 — hazard unit: IF/ID must hold
- redirect_IF in 1 — EX taken branch/jump; flush and refetch
- target_IF in 32 — redirect address, used unmodified
- imem_req_IF out 1 — fetch request, held until ack
- imem_addr_IF out 32 — fetch address, stable while req high
- imem_ack_IF in 1 — data valid this cycle; may arrive in the same cycle as req (zero-wait)
- imem_data_IF in 32 — fetched instruction
- PC_out_IF out 32 — to PC_in_IFID
- inst_out_IF out 32 — to inst_in_IFID
- en_out_IF out 1 — to en_IFID
- NOP_out_IF out 1 — to NOP_IFID

## Operation
- Registers: pc, state, hold buffer (inst), all reset asynchronously: pc=RESET_PC, state=IDLE, buffer=0.
- States: IDLE (one cycle after reset, no request) -> REQ; REQ (request outstanding at pc); HOLD (instruction returned, delivery blocked by stall, req low); DROP (wrong-path request outstanding, data discarded).
- Delivery: an instruction is "ready" when state=REQ with imem_ack_IF=1, or state=HOLD (buffer). PC_out_IF=pc; inst_out_IF=imem_data_IF in REQ, buffer in HOLD.
- Output priority, combinational: redirect_IF -> en=1, NOP=1; else stall_IF -> en=0, NOP=0; else ready -> en=1, NOP=0; else en=1, NOP=1 (bubble).
- REQ, ack, delivered: pc<=pc+PC_STEP, stay REQ. Next request goes out the next cycle, so a zero-wait memory sustains one instruction per cycle.
- REQ, ack, stall, no redirect: buffer<=imem_data_IF, -> HOLD; pc unchanged.
- HOLD, stall released, no redirect: deliver buffer, pc<=pc+PC_STEP, -> REQ.
- Redirect in REQ without ack: pc<=target_IF, -> DROP. Redirect in REQ with ack, or in HOLD: data discarded, pc<=target_IF, -> REQ. Redirect in DROP: pc<=target_IF, stay DROP. Redirect in IDLE: pc<=target_IF, -> REQ.
- DROP: imem_req_IF=1, imem_addr_IF=old address, held in a separate register so the address stays stable. On ack: discard the data, -> REQ at pc.
- imem_req_IF=1 in REQ and DROP only. imem_addr_IF=pc in REQ.
- pc arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check.
- imem_ack_IF in IDLE or HOLD is a protocol violation and is ignored.

## Timing
- While rst_IF is high: imem_req_IF=0, imem_addr_IF=RESET_PC, en_out_IF=0, NOP_out_IF=1, PC_out_IF=RESET_PC, inst_out_IF=0.
- First request is issued in the second cycle after reset deassertion (IDLE lasts one cycle).
- Fetch-to-IF/ID latency is zero extra cycles: the instruction loads into IF/ID at the edge where ack is high and the stall is low.
- A redirect at edge N issues target_IF no earlier than cycle N+1, or after the pending ack if the state is DROP.
- Reset mid-request: the outstanding request is abandoned; memory must tolerate req dropping without ack.

## Structure
- Package if_pkg: state enum {IDLE, REQ, HOLD, DROP}, default PC_STEP and RESET_PC constants.
- Sub-module if_hold_buf: one-entry instruction buffer with load/clear, async reset. The FSM and pc stay in if_fetch_unit.

## Test plan
- Reset release with zero-wait memory returning inst=0x00000013 at each address -> first req at 0x0, then 0x4, 0x8; en=1 and NOP=0 every cycle after the first ack; NOP=1 in the IDLE cycle.
- Memory ack 3 cycles after req -> 3 bubble cycles (en=1, NOP=1), then PC 0x0 delivered; addr stable throughout.
- Stall raised in the ack cycle for 2 cycles -> en=0, state HOLD, req=0; on release the buffered instruction is delivered with PC unchanged; next req at pc+4.
- Redirect to 0x100 with a 2-cycle-latency request outstanding -> NOP=1; stale data dropped on ack; next req at 0x100; delivered PC=0x100.
- Redirect and stall in the same cycle -> en=1, NOP=1 (redirect wins).
- Set pc to 0xFFFFFFFC via redirect, zero-wait memory -> next fetch address 0x00000000.
